priority_encoder_pipe: RTL and testbench

//   Parametrised, pipelined priority encoder for the AdaIN datapath (leading-one

---
 rtl/priority_encoder_pipe.sv | 195 +++++++++++++++++++
 tb/tb_priority_encoder_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_pipe.sv
// Pipelined priority encoder: log2(WIDTH) levels of valid/index combine
// nodes, with a register boundary every PIPE_STRIDE levels. Each beat selects
// MSB-first or LSB-first scanning and carries a sideband tag to the output.
// Handshake is valid/ready with a per-stage ready chain (no skid buffer).
module priority_encoder_pipe #(
    parameter int WIDTH       = 16,
    parameter int PIPE_STRIDE = 2,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_lsb,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH)-1:0]   out_idx,
    output logic [$clog2(WIDTH):0]     out_lzc,
    output logic                       out_zero,
    output logic [TAG_WIDTH-1:0]       out_tag
);

    localparam int L      = $clog2(WIDTH);
    localparam int IW     = (L < 1) ? 1 : L;
    localparam int STRIDE = (PIPE_STRIDE < 1) ? 1 : PIPE_STRIDE;
    localparam int NSTG   = (L + STRIDE - 1) / STRIDE;
    localparam int LZW    = IW + 1;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("priority_encoder_pipe: WIDTH must be a power of two >= 2");
    end
    if (PIPE_STRIDE < 1 || PIPE_STRIDE > L) begin : g_bad_stride
        $error("priority_encoder_pipe: PIPE_STRIDE must be in 1..log2(WIDTH)");
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag
        $error("priority_encoder_pipe: TAG_WIDTH must be >= 1");
    end

    // Tree state after some number of levels: node n holds a valid bit and
    // the index of its winning leaf, counted within that node's subtree.
    // Nodes beyond the live count at a level are kept at zero.
    typedef struct packed {
        logic [WIDTH-1:0]         v;
        logic [WIDTH-1:0][IW-1:0] idx;
    } tree_t;

    // One combine level: pairs (2n+1, 2n) -> n. The high child wins when
    // valid, and its valid bit becomes the new index MSB.
    function automatic tree_t tree_level(input tree_t t, input int lv);
        tree_t r;
        r = '0;
        for (int n = 0; n < WIDTH / 2; n++) begin
            if (n < (WIDTH >> (lv + 1))) begin
                r.v[n]   = t.v[2*n+1] | t.v[2*n];
                r.idx[n] = t.v[2*n+1] ? (t.idx[2*n+1] | (IW'(1) << lv))
                                      : t.idx[2*n];
            end
        end
        return r;
    endfunction

    // The levels owned by one stage; the last stage may own fewer than STRIDE.
    function automatic tree_t run_levels(input tree_t t, input int first);
        tree_t r;
        r = t;
        for (int j = 0; j < STRIDE; j++) begin
            if (first + j < L) begin
                r = tree_level(r, first + j);
            end
        end
        return r;
    endfunction

    tree_t                leaves;
    tree_t                src_t   [NSTG];
    tree_t                res_t   [NSTG];
    tree_t                tree_p  [NSTG];
    logic                 lsb_p   [NSTG];
    logic                 lsb_src [NSTG];
    logic [TAG_WIDTH-1:0] tag_p   [NSTG];
    logic [TAG_WIDTH-1:0] tag_src [NSTG];
    logic [NSTG-1:0]      vld_p;
    logic [NSTG-1:0]      vld_src;
    logic [NSTG-1:0]      rdy;
    logic [NSTG-1:0]      ld;

    logic                 root_v;
    logic [IW-1:0]        root_i;
    logic                 fin_lsb;
    logic [IW-1:0]        fin_idx;
    logic [LZW-1:0]       fin_lzc;
    logic                 fin_zero;

    // Leaf level: LSB-first beats are bit-reversed so the same MSB-first tree serves both modes.
    always_comb begin
        leaves = '0;
        for (int i = 0; i < WIDTH; i++) begin
            leaves.v[i] = in_lsb ? in_data[WIDTH-1-i] : in_data[i];
        end
    end

    // Stage inputs: stage 0 takes the input port, later stages take the previous stage register.
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            src_t[k]   = '0;
            lsb_src[k] = 1'b0;
            tag_src[k] = '0;
        end
        vld_src    = '0;
        src_t[0]   = leaves;
        lsb_src[0] = in_lsb;
        tag_src[0] = in_tag;
        vld_src[0] = in_valid;
        for (int k = 1; k < NSTG; k++) begin
            src_t[k]   = tree_p[k-1];
            lsb_src[k] = lsb_p[k-1];
            tag_src[k] = tag_p[k-1];
            vld_src[k] = vld_p[k-1];
        end
    end

    // Combinational tree levels owned by each stage.
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            res_t[k] = run_levels(src_t[k], k * STRIDE);
        end
    end

    // Ready chain from the output back to the input; a stage loads only when ready.
    always_comb begin
        logic nxt;
        nxt = out_ready;
        rdy = '0;
        ld  = '0;
        for (int k = NSTG - 1; k >= 0; k--) begin
            rdy[k] = ~vld_p[k] | nxt;
            ld[k]  = rdy[k] & vld_src[k];
            nxt    = rdy[k];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_p[NSTG-1];

    // Root of the finished tree mapped back to a bit position and a zero count in scan direction.
    always_comb begin
        fin_lsb  = lsb_src[NSTG-1];
        root_v   = res_t[NSTG-1].v[0];
        root_i   = res_t[NSTG-1].idx[0];
        fin_zero = ~root_v;
        fin_idx  = '0;
        fin_lzc  = LZW'(WIDTH);
        if (root_v) begin
            fin_idx = fin_lsb ? (IW'(WIDTH - 1) - root_i) : root_i;
            fin_lzc = fin_lsb ? {1'b0, fin_idx} : {1'b0, IW'(WIDTH - 1) - fin_idx};
        end
    end

    // Stage boundary: valid bits and the registered result; reset drops every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p    <= '0;
            out_idx  <= '0;
            out_lzc  <= '0;
            out_zero <= 1'b0;
            out_tag  <= '0;
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (rdy[k]) begin
                    vld_p[k] <= vld_src[k];
                end
            end
            if (ld[NSTG-1]) begin
                out_idx  <= fin_idx;
                out_lzc  <= fin_lzc;
                out_zero <= fin_zero;
                out_tag  <= tag_src[NSTG-1];
            end
        end
    end

    // Stage boundary: intermediate tree, mode and tag, held while the stage is stalled.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NSTG - 1; k++) begin
            if (ld[k]) begin
                tree_p[k] <= res_t[k];
                lsb_p[k]  <= lsb_src[k];
                tag_p[k]  <= tag_src[k];
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_pipe.sv
// Bench for priority_encoder_pipe: directed corner beats, random streaming,
// backpressure, mid-stream reset on a 16/2 instance, plus one-hot walks on
// several WIDTH/PIPE_STRIDE combinations.
module tb_priority_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst_n, sw_rst_n;
    logic        in_valid, in_ready, in_lsb, out_valid, out_ready, out_zero;
    logic [15:0] in_data;
    logic [3:0]  in_tag, out_tag, out_idx;
    logic [4:0]  out_lzc;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pop_cyc [$];

    typedef struct packed {
        logic [3:0] idx;
        logic [4:0] lzc;
        logic       zero;
        logic [3:0] tag;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    priority_encoder_pipe #(.WIDTH(16), .PIPE_STRIDE(2), .TAG_WIDTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_lsb(in_lsb), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_lzc(out_lzc), .out_zero(out_zero), .out_tag(out_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: scan for the first set bit in the chosen direction.
    function automatic exp_t model(input logic [15:0] d, input logic lsb, input logic [3:0] tag);
        exp_t e;
        int   p;
        e.tag = tag;
        if (d == 16'h0) begin
            e.zero = 1'b1;
            e.idx  = 4'd0;
            e.lzc  = 5'd16;
        end else begin
            p = -1;
            for (int i = 0; i < 16; i++) begin
                if (lsb) begin
                    if (d[i] && p < 0) p = i;
                end else begin
                    if (d[i]) p = i;
                end
            end
            e.zero = 1'b0;
            e.idx  = 4'(p);
            e.lzc  = lsb ? 5'(p) : 5'(15 - p);
        end
        return e;
    endfunction

    task automatic send(input logic [15:0] d, input logic lsb, input logic [3:0] tag);
        int waitc;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_lsb   = lsb;
        in_tag   = tag;
        #1;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        check("send_ready", in_ready, 1);
        if (in_ready) sb.push_back(model(d, lsb, tag));
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #3;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic directed(input logic [15:0] d, input logic lsb, input logic [3:0] tag,
                            input int ei, input int el, input int ez);
        send(d, lsb, tag);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        check("lat_early", out_valid, 0);
        @(negedge clk);
        #2;
        check("lat_hit", out_valid, 1);
        check("d_idx", out_idx, ei);
        check("d_lzc", out_lzc, el);
        check("d_zero", out_zero, ez);
        check("d_tag", out_tag, tag);
    endtask

    // Scoreboard: a beat that is valid and accepted at this point transfers on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_idx", out_idx, e.idx);
                check("out_lzc", out_lzc, e.lzc);
                check("out_zero", out_zero, e.zero);
                check("out_tag", out_tag, e.tag);
                pop_cyc.push_back(cyc);
            end
        end
    end

    localparam int SW_W [5] = '{2, 8, 8, 64, 64};
    localparam int SW_S [5] = '{1, 1, 3, 1, 6};

    for (genvar g = 0; g < 5; g++) begin : g_sweep
        localparam int W  = SW_W[g];
        localparam int S  = SW_S[g];
        localparam int LW = $clog2(W);
        localparam int NS = (LW + S - 1) / S;
        logic          iv, ir, il, ov, oz, done;
        logic [W-1:0]  id;
        logic [3:0]    ot;
        logic [LW-1:0] oi;
        logic [LW:0]   ol;

        priority_encoder_pipe #(.WIDTH(W), .PIPE_STRIDE(S), .TAG_WIDTH(4)) u_sw (
            .clk(clk), .rst_n(sw_rst_n),
            .in_valid(iv), .in_ready(ir), .in_data(id),
            .in_lsb(il), .in_tag(4'(g)),
            .out_valid(ov), .out_ready(1'b1), .out_idx(oi),
            .out_lzc(ol), .out_zero(oz), .out_tag(ot)
        );

        initial begin
            int lat;
            done = 1'b0;
            iv   = 1'b0;
            il   = 1'b0;
            id   = '0;
            wait (sw_rst_n === 1'b1);
            for (int b = 0; b < W; b++) begin
                @(negedge clk);
                iv    = 1'b1;
                il    = b[0];
                id    = '0;
                id[b] = 1'b1;
                #1;
                check("sw_ready", ir, 1);
                @(posedge clk);
                #1;
                iv  = 1'b0;
                lat = 1;
                while (!ov && lat < 40) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check("sw_lat", lat, NS);
                check("sw_idx", oi, b);
                check("sw_lzc", ol, il ? b : W - 1 - b);
                check("sw_zero", oz, 0);
                check("sw_tag", ot, g);
            end
            done = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d1, d2, d3;
        logic        l1, l2, l3;
        exp_t        e1;
        int          n0, waitc;

        rst_n     = 1'b0;
        sw_rst_n  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_lsb    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_idx", out_idx, 0);
        check("rst_lzc", out_lzc, 0);
        check("rst_zero", out_zero, 0);
        check("rst_tag", out_tag, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        sw_rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        directed(16'h0810, 1'b0, 4'd3, 11, 4, 0);
        directed(16'h0810, 1'b1, 4'd5, 4, 4, 0);
        directed(16'h0000, 1'b0, 4'd6, 0, 16, 1);
        directed(16'h0000, 1'b1, 4'd2, 0, 16, 1);
        directed(16'h8000, 1'b1, 4'd7, 15, 15, 0);
        directed(16'h0001, 1'b0, 4'd8, 0, 15, 0);

        // Streaming with random data shapes and random scan mode.
        n0 = pop_cyc.size();
        for (int i = 0; i < 100; i++) begin
            logic [15:0] d;
            case ($urandom_range(0, 3))
                0:       d = 16'h0;
                1:       d = 16'h1 << $urandom_range(0, 15);
                2:       d = 16'($urandom);
                default: d = 16'($urandom) >> $urandom_range(0, 15);
            endcase
            send(d, 1'($urandom_range(0, 1)), 4'($urandom));
        end
        idle();
        drain();
        check("stream_count", pop_cyc.size() - n0, 100);
        if (pop_cyc.size() - n0 == 100)
            check("stream_span", pop_cyc[pop_cyc.size()-1] - pop_cyc[n0], 99);

        // Backpressure: output stalled, two beats fill the pipe, third must wait.
        @(negedge clk);
        out_ready = 1'b0;
        d1 = 16'h0480; l1 = 1'b0;
        d2 = 16'h0480; l2 = 1'b1;
        d3 = 16'h7000; l3 = 1'b1;
        e1 = model(d1, l1, 4'd10);
        send(d1, l1, 4'd10);
        send(d2, l2, 4'd11);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d3;
        in_lsb   = l3;
        in_tag   = 4'd12;
        #1;
        check("bp_in_ready", in_ready, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_idx", out_idx, e1.idx);
            check("bp_lzc", out_lzc, e1.lzc);
            check("bp_tag", out_tag, e1.tag);
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        out_ready = 1'b1;
        send(d3, l3, 4'd12);
        idle();
        drain();

        // Mid-stream reset: two beats in flight are discarded.
        send(16'h00F0, 1'b0, 4'd13);
        send(16'h0F00, 1'b1, 4'd14);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        #2;
        check("mrst_valid", out_valid, 0);
        check("mrst_idx", out_idx, 0);
        check("mrst_lzc", out_lzc, 0);
        check("mrst_zero", out_zero, 0);
        check("mrst_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mrst_in_ready", in_ready, 1);
        n0 = pop_cyc.size();
        send(16'h0204, 1'b1, 4'd9);
        idle();
        drain();
        check("mrst_one_out", pop_cyc.size() - n0, 1);

        waitc = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
                 g_sweep[3].done && g_sweep[4].done) && waitc < 5000) begin
            @(negedge clk);
            waitc++;
        end
        check("sweep_done", g_sweep[0].done && g_sweep[1].done && g_sweep[2].done &&
                            g_sweep[3].done && g_sweep[4].done, 1);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
